// File: rtl/dct_nios_cpu_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiplier (Nios II MUL/MULX) built from half-width partial products.
// Define DCT_NIOS_MULT_HI_EN to build the high-word ops (MULXUU/MULXSU/MULXSS); otherwise only MUL is supported.
module dct_nios_cpu_mult_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int HALF = DATA_W / 2;
  localparam int NS   = LATENCY - 1;

  // Handshake: a request is taken on a rising edge with in_valid=1 and en=1; there is no
  // back-pressure, en=0 freezes every stage and the requester must hold its request.

  logic [DATA_W-1:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;
  assign a_lo_x = {{HALF{1'b0}}, in_a[HALF-1:0]};
  assign a_hi_x = {{HALF{1'b0}}, in_a[DATA_W-1:HALF]};
  assign b_lo_x = {{HALF{1'b0}}, in_b[HALF-1:0]};
  assign b_hi_x = {{HALF{1'b0}}, in_b[DATA_W-1:HALF]};

  logic              load;
  logic              v1_q, v1_d;
  logic [1:0]        op1_q, op1_d;
  logic [TAG_W-1:0]  tag1_q, tag1_d;
  logic [DATA_W-1:0] pp_ll_q, pp_ll_d, pp_lh_q, pp_lh_d, pp_hl_q, pp_hl_d;
`ifdef DCT_NIOS_MULT_HI_EN
  logic [DATA_W-1:0] pp_hh_q, pp_hh_d, a1_q, a1_d, b1_q, b1_d;
  logic              sa1_q, sa1_d, sb1_q, sb1_d;
`endif

  always_comb begin
    load     = en & in_valid;
    v1_d     = en ? in_valid : v1_q;
    op1_d    = load ? in_op : op1_q;
    tag1_d   = load ? in_tag : tag1_q;
    pp_ll_d  = load ? a_lo_x * b_lo_x : pp_ll_q;
    pp_lh_d  = load ? a_lo_x * b_hi_x : pp_lh_q;
    pp_hl_d  = load ? a_hi_x * b_lo_x : pp_hl_q;
`ifdef DCT_NIOS_MULT_HI_EN
    pp_hh_d  = load ? a_hi_x * b_hi_x : pp_hh_q;
    a1_d     = load ? in_a : a1_q;
    b1_d     = load ? in_b : b1_q;
    sa1_d    = load ? (in_a[DATA_W-1] & in_op[1]) : sa1_q;
    sb1_d    = load ? (in_b[DATA_W-1] & in_op[1] & in_op[0]) : sb1_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      op1_q   <= '0;
      tag1_q  <= '0;
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
`ifdef DCT_NIOS_MULT_HI_EN
      pp_hh_q <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      sa1_q   <= 1'b0;
      sb1_q   <= 1'b0;
`endif
    end else begin
      v1_q    <= v1_d;
      op1_q   <= op1_d;
      tag1_q  <= tag1_d;
      pp_ll_q <= pp_ll_d;
      pp_lh_q <= pp_lh_d;
      pp_hl_q <= pp_hl_d;
`ifdef DCT_NIOS_MULT_HI_EN
      pp_hh_q <= pp_hh_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      sa1_q   <= sa1_d;
      sb1_q   <= sb1_d;
`endif
    end
  end

  // Stage 2 sum: unsigned product, then subtract the other operand for each negative signed input.
  logic [DATA_W-1:0] p_res;
  logic              p_err;
`ifdef DCT_NIOS_MULT_HI_EN
  logic [2*DATA_W-1:0] p_full;
  always_comb begin
    p_full = {{DATA_W{1'b0}}, pp_ll_q}
           + ({{DATA_W{1'b0}}, pp_lh_q} << HALF)
           + ({{DATA_W{1'b0}}, pp_hl_q} << HALF)
           + {pp_hh_q, {DATA_W{1'b0}}};
    p_full = p_full - (sa1_q ? {b1_q, {DATA_W{1'b0}}} : '0)
                    - (sb1_q ? {a1_q, {DATA_W{1'b0}}} : '0);
    p_res  = (op1_q == 2'b00) ? p_full[DATA_W-1:0] : p_full[2*DATA_W-1:DATA_W];
    p_err  = 1'b0;
  end
`else
  logic [DATA_W-1:0] p_lo;
  always_comb begin
    p_lo  = pp_ll_q + (pp_lh_q << HALF) + (pp_hl_q << HALF);
    p_res = (op1_q == 2'b00) ? p_lo : '0;
    p_err = (op1_q != 2'b00);
  end
`endif

  logic [NS-1:0]             vld_q, vld_d;
  logic [NS-1:0]             err_q, err_d;
  logic [NS-1:0][DATA_W-1:0] res_q, res_d;
  logic [NS-1:0][TAG_W-1:0]  tag_q, tag_d;

  // Result/tag/err registers load only when a valid op moves in, so outputs hold between ops.
  always_comb begin
    vld_d[0] = en ? v1_q : vld_q[0];
    res_d[0] = (en & v1_q) ? p_res  : res_q[0];
    tag_d[0] = (en & v1_q) ? tag1_q : tag_q[0];
    err_d[0] = (en & v1_q) ? p_err  : err_q[0];
    for (int k = 1; k < NS; k++) begin
      vld_d[k] = en ? vld_q[k-1] : vld_q[k];
      res_d[k] = (en & vld_q[k-1]) ? res_q[k-1] : res_q[k];
      tag_d[k] = (en & vld_q[k-1]) ? tag_q[k-1] : tag_q[k];
      err_d[k] = (en & vld_q[k-1]) ? err_q[k-1] : err_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      err_q <= '0;
      res_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      res_q <= res_d;
      tag_q <= tag_d;
    end
  end

  assign out_valid  = vld_q[NS-1];
  assign out_result = res_q[NS-1];
  assign out_tag    = tag_q[NS-1];
  assign out_err    = err_q[NS-1];

endmodule
